// File: rtl/dm_stall_mem.sv
// -----------------------------------------------------------------------------
// dm_stall_mem
//
// Behavioural data memory for the CPU data port. It sits behind the MEM stage.
// It drives a ready handshake that can hold the pipeline for a programmable
// number of wait cycles. It also flags accesses outside its address window.
// On hardware a BRAM core takes its place.
//
// Parameters
//   WORDNUM       number of 32-bit words (power of two)
//   ADDR_BASE     byte address of word 0 (aligned to 4*WORDNUM)
//   STALL_PERIOD  one stalled access per STALL_PERIOD completed accesses
//                 (0 disables stalling)
//   STALL_CYCLES  wait cycles inserted on a stalled access (0 disables)
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   pc       in   PC of the accessing instruction (trace only)
//   addr     in   byte address, bits [1:0] ignored
//   ce       in   chip enable
//   we       in   write request
//   re       in   read request
//   be       in   byte enables, be[i] selects din[8i+7:8i]
//   din      in   write data
//   dout     out  word at addr (0 when out of range), valid with ready
//   ready    out  access completes this cycle
//   fault    out  current request address is outside the window
// -----------------------------------------------------------------------------
module dm_stall_mem #(
    parameter int unsigned WORDNUM      = 4096,
    parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
    parameter int unsigned STALL_PERIOD = 16,
    parameter int unsigned STALL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic        ce,
    input  logic        we,
    input  logic        re,
    input  logic [3:0]  be,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        ready,
    output logic        fault
);

    localparam int unsigned IW       = (WORDNUM > 1) ? $clog2(WORDNUM) : 1;
    localparam logic        STALL_EN = (STALL_PERIOD != 0) && (STALL_CYCLES != 0);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Expand the four byte enables into a 32-bit bit mask.
    function automatic logic [31:0] expand_be(input logic [3:0] b);
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{b[i]}};
        end
        return m;
    endfunction

    // Merge new data into the old word under a bit mask.
    function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [31:0] mask);
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    logic [31:0] mem_r [WORDNUM];

    state_t      state_r;
    logic [31:0] acc_cnt_r;
    logic [31:0] wait_cnt_r;
    logic [31:0] addr_q_r;

    logic          req_s;
    logic [31:0]   offset_s;
    logic          in_range_s;
    logic [IW-1:0] index_s;
    logic          complete_s;
    logic          stall_start_s;
    logic          leave_s;
    logic [31:0]   acc_next_s;
    logic          write_s;
    logic          unused_s;

    assign req_s    = ce & (re | we);
    assign offset_s = addr - ADDR_BASE;
    // The subtraction keeps the upper-bound test free of 32-bit overflow when
    // the window ends at the top of the address space.
    assign in_range_s = (addr >= ADDR_BASE) && ({2'b00, offset_s[31:2]} < WORDNUM);
    assign index_s    = offset_s[IW+1:2];

    // The PC and the byte offset inside a word do not affect the access.
    assign unused_s = ^{pc, offset_s[1:0]};

    // Decide this cycle's handshake outcome from the current state.
    always_comb begin
        complete_s    = 1'b0;
        stall_start_s = 1'b0;
        leave_s       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (req_s && in_range_s) begin
                    if (STALL_EN && (acc_cnt_r == 32'd0)) begin
                        stall_start_s = 1'b1;
                    end else begin
                        complete_s = 1'b1;
                    end
                end else begin
                    complete_s = 1'b0;
                end
            end
            S_WAIT: begin
                // A dropped or moved request abandons the stalled access.
                if (!req_s || (addr != addr_q_r)) begin
                    leave_s = 1'b1;
                end else if (wait_cnt_r == 32'd0) begin
                    complete_s = 1'b1;
                end else begin
                    leave_s = 1'b0;
                end
            end
            default: begin
                leave_s = 1'b1;
            end
        endcase
    end

    // Next value of the completed-access counter, wrapping at STALL_PERIOD.
    always_comb begin
        if ((acc_cnt_r + 32'd1) >= STALL_PERIOD) begin
            acc_next_s = 32'd0;
        end else begin
            acc_next_s = acc_cnt_r + 32'd1;
        end
    end

    // Outputs are gated by reset so nothing completes while reset is held.
    assign fault   = reset_n & req_s & ~in_range_s;
    assign ready   = reset_n & (complete_s | (req_s & ~in_range_s));
    assign write_s = reset_n & complete_s & we;
    assign dout    = in_range_s ? mem_r[index_s] : 32'd0;

    // Handshake FSM: idle/wait state, wait counter, latched address, access count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= S_IDLE;
            acc_cnt_r  <= 32'd0;
            wait_cnt_r <= 32'd0;
            addr_q_r   <= 32'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (stall_start_s) begin
                        state_r    <= S_WAIT;
                        addr_q_r   <= addr;
                        wait_cnt_r <= STALL_CYCLES - 32'd1;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (complete_s || leave_s) begin
                        state_r <= S_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 32'd1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
            if (complete_s) begin
                acc_cnt_r <= acc_next_s;
            end else begin
                acc_cnt_r <= acc_cnt_r;
            end
        end
    end

    // Storage array: byte-merged write on a completing in-range write.
    always_ff @(posedge clk) begin
        if (write_s) begin
            mem_r[index_s] <= merge_word(mem_r[index_s], din, expand_be(be));
        end
    end

endmodule

// File: tb/tb_dm_stall_mem.sv
module tb_dm_stall_mem;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc;
    logic [31:0] addr;
    logic        ce;
    logic        we;
    logic        re;
    logic [3:0]  be;
    logic [31:0] din;

    logic [31:0] dout_def, dout_stl, dout_flt;
    logic        ready_def, ready_stl, ready_flt;
    logic        fault_def, fault_stl, fault_flt;
    logic        tb_unused;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign tb_unused = ^dout_stl;

    dm_stall_mem u_def (
        .clk(clk), .reset_n(reset_n), .pc(pc), .addr(addr), .ce(ce), .we(we),
        .re(re), .be(be), .din(din), .dout(dout_def), .ready(ready_def), .fault(fault_def)
    );

    dm_stall_mem #(.STALL_PERIOD(4), .STALL_CYCLES(3)) u_stl (
        .clk(clk), .reset_n(reset_n), .pc(pc), .addr(addr), .ce(ce), .we(we),
        .re(re), .be(be), .din(din), .dout(dout_stl), .ready(ready_stl), .fault(fault_stl)
    );

    dm_stall_mem #(.WORDNUM(1024), .ADDR_BASE(32'h0000_1000)) u_flt (
        .clk(clk), .reset_n(reset_n), .pc(pc), .addr(addr), .ce(ce), .we(we),
        .re(re), .be(be), .din(din), .dout(dout_flt), .ready(ready_flt), .fault(fault_flt)
    );

    task automatic drive(input logic c, input logic w, input logic r,
                         input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
        ce   = c;
        we   = w;
        re   = r;
        be   = b;
        addr = a;
        din  = d;
        pc   = pc + 32'd4;
    endtask

    task automatic idle_bus();
        ce = 1'b0; we = 1'b0; re = 1'b0; be = 4'b0000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_bus();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 4'b1111, 32'h0000_0FFC, 32'h0);
        #2;
        tests_run++;
        if (ready_def !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_def got %b want 0", ready_def); end
        tests_run++;
        if (ready_flt !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_flt got %b want 0", ready_flt); end
        tests_run++;
        if (fault_flt !== 1'b0) begin tests_failed++; $display("FAIL reset_fault_flt got %b want 0", fault_flt); end
        step();
        tests_run++;
        if (ready_stl !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_stl got %b want 0", ready_stl); end
        idle_bus();
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 4'b1111, 32'h10, 32'h1234_5678);
        @(negedge clk);
        tests_run++;
        if (ready_def !== 1'b0) begin tests_failed++; $display("FAIL basic_stall_c1 ready got %b want 0", ready_def); end
        tests_run++;
        if (fault_def !== 1'b0) begin tests_failed++; $display("FAIL basic_fault got %b want 0", fault_def); end
        step();
        @(negedge clk);
        tests_run++;
        if (ready_def !== 1'b1) begin tests_failed++; $display("FAIL basic_stall_c2 ready got %b want 1", ready_def); end
        step();
        drive(1'b1, 1'b0, 1'b1, 4'b0000, 32'h10, 32'h0);
        @(negedge clk);
        tests_run++;
        if (ready_def !== 1'b1) begin tests_failed++; $display("FAIL basic_read_ready got %b want 1", ready_def); end
        tests_run++;
        if (dout_def !== 32'h1234_5678) begin tests_failed++; $display("FAIL basic_read_data got %h want 12345678", dout_def); end
        step();
        idle_bus();
    endtask

    task automatic test_byte_merge();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 4'b1111, 32'h20, 32'hAABB_CCDD);
        step();
        @(negedge clk);
        tests_run++;
        if (ready_def !== 1'b1) begin tests_failed++; $display("FAIL merge_init_ready got %b want 1", ready_def); end
        step();
        drive(1'b1, 1'b1, 1'b1, 4'b0101, 32'h20, 32'h1122_3344);
        @(negedge clk);
        tests_run++;
        if (ready_def !== 1'b1) begin tests_failed++; $display("FAIL merge_ready got %b want 1", ready_def); end
        tests_run++;
        if (dout_def !== 32'hAABB_CCDD) begin tests_failed++; $display("FAIL merge_prewrite got %h want aabbccdd", dout_def); end
        step();
        drive(1'b1, 1'b0, 1'b1, 4'b0000, 32'h20, 32'h0);
        @(negedge clk);
        tests_run++;
        if (dout_def !== 32'hAA22_CC44) begin tests_failed++; $display("FAIL merge_word got %h want aa22cc44", dout_def); end
        step();
        drive(1'b1, 1'b1, 1'b0, 4'b0000, 32'h20, 32'hFFFF_FFFF);
        @(negedge clk);
        tests_run++;
        if (ready_def !== 1'b1) begin tests_failed++; $display("FAIL merge_be0_ready got %b want 1", ready_def); end
        step();
        drive(1'b1, 1'b0, 1'b1, 4'b0000, 32'h20, 32'h0);
        @(negedge clk);
        tests_run++;
        if (dout_def !== 32'hAA22_CC44) begin tests_failed++; $display("FAIL merge_be0_word got %h want aa22cc44", dout_def); end
        step();
        idle_bus();
    endtask

    task automatic test_stall_cadence();
        int   n;
        int   exp_n;
        logic got;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 1'b0, 1'b1, 4'b0000, 32'h100 + 32'(4 * k), 32'h0);
            n   = 0;
            got = 1'b0;
            while (!got && n < 10) begin
                @(negedge clk);
                n++;
                got = ready_stl;
                tests_run++;
                if (fault_stl !== 1'b0) begin tests_failed++; $display("FAIL cadence_fault acc %0d got %b want 0", k + 1, fault_stl); end
                step();
            end
            exp_n = ((k % 4) == 0) ? 4 : 1;
            tests_run++;
            if (!got || n != exp_n) begin
                tests_failed++;
                $display("FAIL cadence_acc%0d cycles got %0d (ready %b) want %0d", k + 1, n, got, exp_n);
            end
        end
        idle_bus();
    endtask

    task automatic test_abandon();
        int   n;
        logic got;
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 4'b0000, 32'h40, 32'h0);
        @(negedge clk);
        tests_run++;
        if (ready_stl !== 1'b0) begin tests_failed++; $display("FAIL abandon_c1 ready got %b want 0", ready_stl); end
        step();
        @(negedge clk);
        tests_run++;
        if (ready_stl !== 1'b0) begin tests_failed++; $display("FAIL abandon_c2 ready got %b want 0", ready_stl); end
        step();
        drive(1'b1, 1'b0, 1'b1, 4'b0000, 32'h44, 32'h0);
        @(negedge clk);
        tests_run++;
        if (ready_stl !== 1'b0) begin tests_failed++; $display("FAIL abandon_switch ready got %b want 0", ready_stl); end
        step();
        n   = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            got = ready_stl;
            step();
        end
        tests_run++;
        if (!got || n != 4) begin tests_failed++; $display("FAIL abandon_restall cycles got %0d (ready %b) want 4", n, got); end
        drive(1'b1, 1'b0, 1'b1, 4'b0000, 32'h48, 32'h0);
        @(negedge clk);
        tests_run++;
        if (ready_stl !== 1'b1) begin tests_failed++; $display("FAIL abandon_next ready got %b want 1", ready_stl); end
        step();
        idle_bus();
    endtask

    task automatic test_fault();
        logic [31:0] bad [2];
        bad[0] = 32'h0000_0FFC;
        bad[1] = 32'h0000_2000;
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 4'b1111, 32'h1FFC, 32'hCAFE_F00D);
        @(negedge clk);
        tests_run++;
        if (ready_flt !== 1'b0 || fault_flt !== 1'b0) begin
            tests_failed++; $display("FAIL fault_top_c1 ready/fault got %b/%b want 0/0", ready_flt, fault_flt);
        end
        step();
        @(negedge clk);
        tests_run++;
        if (ready_flt !== 1'b1) begin tests_failed++; $display("FAIL fault_top_c2 ready got %b want 1", ready_flt); end
        step();
        drive(1'b1, 1'b1, 1'b0, 4'b1111, 32'h1000, 32'h55AA_55AA);
        @(negedge clk);
        tests_run++;
        if (ready_flt !== 1'b1) begin tests_failed++; $display("FAIL fault_base_ready got %b want 1", ready_flt); end
        step();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 4'b1111, bad[i], 32'hDEAD_BEEF);
            @(negedge clk);
            tests_run++;
            if (ready_flt !== 1'b1 || fault_flt !== 1'b1 || dout_flt !== 32'h0) begin
                tests_failed++;
                $display("FAIL fault_oor_%h ready/fault/dout got %b/%b/%h want 1/1/00000000",
                         bad[i], ready_flt, fault_flt, dout_flt);
            end
            step();
        end
        drive(1'b1, 1'b0, 1'b1, 4'b0000, 32'h1FFC, 32'h0);
        @(negedge clk);
        tests_run++;
        if (ready_flt !== 1'b1 || fault_flt !== 1'b0 || dout_flt !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("FAIL fault_top_read ready/fault/dout got %b/%b/%h want 1/0/cafef00d", ready_flt, fault_flt, dout_flt);
        end
        step();
        drive(1'b1, 1'b0, 1'b1, 4'b0000, 32'h1000, 32'h0);
        @(negedge clk);
        tests_run++;
        if (dout_flt !== 32'h55AA_55AA) begin tests_failed++; $display("FAIL fault_base_read got %h want 55aa55aa", dout_flt); end
        step();
        idle_bus();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 4'b1111, 32'h30, 32'h0102_0304);
        step();
        @(negedge clk);
        tests_run++;
        if (ready_def !== 1'b1) begin tests_failed++; $display("FAIL rmw_prep ready got %b want 1", ready_def); end
        step();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 4'b1111, 32'h30, 32'hFFFF_FFFF);
        @(negedge clk);
        tests_run++;
        if (ready_def !== 1'b0) begin tests_failed++; $display("FAIL rmw_c1 ready got %b want 0", ready_def); end
        step();
        #1;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (ready_def !== 1'b0) begin tests_failed++; $display("FAIL rmw_async ready got %b want 0", ready_def); end
        step();
        idle_bus();
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 4'b0000, 32'h30, 32'h0);
        @(negedge clk);
        tests_run++;
        if (ready_def !== 1'b0) begin tests_failed++; $display("FAIL rmw_restall ready got %b want 0", ready_def); end
        step();
        @(negedge clk);
        tests_run++;
        if (ready_def !== 1'b1 || dout_def !== 32'h0102_0304) begin
            tests_failed++;
            $display("FAIL rmw_retained ready/dout got %b/%h want 1/01020304", ready_def, dout_def);
        end
        step();
        idle_bus();
    endtask

    initial begin
        pc      = 32'h0;
        reset_n = 1'b0;
        addr    = 32'h0;
        din     = 32'h0;
        idle_bus();
        test_reset();
        test_basic();
        test_byte_merge();
        test_stall_cadence();
        test_abandon();
        test_fault();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
